// File: rtl/icache_if.sv
// icache_sa bus bundle: CPU fetch side, memory word-beat side, perf counters.
// slave = cache side, master = CPU/memory environment side.
interface icache_if #(
  parameter int ADDR_W = 16
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              flush;
  logic              cpu_ready;
  logic              cpu_valid;
  logic [31:0]       cpu_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;
  logic [31:0]       hit_cnt;
  logic [31:0]       miss_cnt;

  modport slave (
    input  cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    output cpu_ready, cpu_valid, cpu_rdata, mem_req, mem_addr,
    output hit_cnt, miss_cnt
  );

  modport master (
    output cpu_req, cpu_addr, flush, mem_ack, mem_rdata,
    input  cpu_ready, cpu_valid, cpu_rdata, mem_req, mem_addr,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/icache_sa.sv
// Set-associative read-only I-cache, LRU, line refill by word beats, flush.
// Optional hit/miss counters under `ICACHE_PERF_EN.
module icache_sa #(
  parameter int ADDR_W     = 16,
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4
) (
  input  logic      clk,
  input  logic      rst,
  icache_if.slave   bus
);
  localparam int WO = $clog2(LINE_WORDS);
  localparam int IX = $clog2(SETS);
  localparam int TW = ADDR_W - IX - WO - 2;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t            state;
  logic [31:0]       dmem  [WAYS][SETS][LINE_WORDS];
  logic [TW-1:0]     tag_q [WAYS][SETS];
  logic [WAYS-1:0]   valid_q [SETS];
  logic [SETS-1:0]   lru_q;
  logic [ADDR_W-3:0] req_word;
  logic              victim;
  logic [WO-1:0]     beat;
  logic              flush_pend;
  logic              cpu_valid;
  logic [31:0]       cpu_rdata;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;

  logic [TW-1:0]   a_tag, r_tag;
  logic [IX-1:0]   a_idx, r_idx;
  logic [WO-1:0]   a_wo, r_wo;
  logic [WAYS-1:0] hit_vec;
  logic            hit, hit_way, victim_c;
  logic            accept, ack, last;
  logic            unused_lsb;

  assign a_tag = bus.cpu_addr[ADDR_W-1 -: TW];
  assign a_idx = bus.cpu_addr[WO+2 +: IX];
  assign a_wo  = bus.cpu_addr[2 +: WO];
  assign r_tag = req_word[ADDR_W-3 -: TW];
  assign r_idx = req_word[WO +: IX];
  assign r_wo  = req_word[WO-1:0];
  assign unused_lsb = ^bus.cpu_addr[1:0];

  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++)
      hit_vec[w] = valid_q[a_idx][w] && (tag_q[w][a_idx] == a_tag);
  end

  assign hit     = |hit_vec;
  assign hit_way = (WAYS == 2) ? hit_vec[WAYS-1] : 1'b0;

  // lru_q[set] names the way to evict next
  always_comb begin
    victim_c = 1'b0;
    if (WAYS == 2 && valid_q[a_idx][0])
      victim_c = valid_q[a_idx][WAYS-1] ? lru_q[a_idx] : 1'b1;
  end

  assign bus.cpu_ready = (state == IDLE) && !flush_pend;
  assign accept = bus.cpu_ready && bus.cpu_req && !bus.flush;
  assign ack    = (state == REFILL) && mem_req && bus.mem_ack;
  assign last   = &beat;

  always_ff @(posedge clk) begin
    if (ack) begin
      dmem[victim][r_idx][beat] <= bus.mem_rdata;
      if (last) tag_q[victim][r_idx] <= r_tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      lru_q      <= '0;
      req_word   <= '0;
      victim     <= 1'b0;
      beat       <= '0;
      flush_pend <= 1'b0;
      cpu_valid  <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.flush || flush_pend) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            flush_pend <= 1'b0;
          end else if (accept) begin
            if (hit) begin
              lru_q[a_idx] <= ~hit_way;
              cpu_rdata    <= dmem[hit_way][a_idx][a_wo];
              cpu_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              req_word <= bus.cpu_addr[ADDR_W-1:2];
              victim   <= victim_c;
              beat     <= '0;
              mem_req  <= 1'b1;
              mem_addr <= {bus.cpu_addr[ADDR_W-1:WO+2],
                           {WO{1'b0}}, 2'b00};
              state    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (bus.flush) flush_pend <= 1'b1;
          if (ack) begin
            if (beat == r_wo) cpu_rdata <= bus.mem_rdata;
            if (last) begin
              valid_q[r_idx][victim] <= 1'b1;
              lru_q[r_idx] <= ~victim;
              mem_req      <= 1'b0;
              cpu_valid    <= 1'b1;
              state        <= DONE;
            end else begin
              beat     <= beat + 1'b1;
              mem_addr <= {req_word[ADDR_W-3:WO],
                           beat + 1'b1, 2'b00};
            end
          end
        end
        DONE: begin
          if (bus.flush) flush_pend <= 1'b1;
          cpu_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_valid = cpu_valid;
  assign bus.cpu_rdata = cpu_rdata;
  assign bus.mem_req   = mem_req;
  assign bus.mem_addr  = mem_addr;

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt, miss_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
    end else if (accept) begin
      if (hit && hit_cnt != '1)   hit_cnt  <= hit_cnt + 1'b1;
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign bus.hit_cnt  = hit_cnt;
  assign bus.miss_cnt = miss_cnt;
`else
  assign bus.hit_cnt  = '0;
  assign bus.miss_cnt = '0;
`endif
endmodule

// File: tb/tb_icache_sa.sv
// Bench for icache_sa: vector table, corner sequences, random vs LRU model.
// Counters checked against the model when ICACHE_PERF_EN is defined.
module tb_icache_sa;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_if #(.ADDR_W(16)) bus();

  icache_sa #(
    .ADDR_W(16), .WAYS(2), .SETS(64), .LINE_WORDS(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int mem_wait = 0;
  int ack_total = 0;
  logic [15:0] cur_addr = '0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [15:0] a);
    if (a[15:4] == 12'h004) return 32'hA0 + 32'(a[3:2]);
    return {a ^ 16'hC3A5, a};
  endfunction

  // Memory: acks each beat after mem_wait idle cycles, checks hold/addr
  int cnt = 0;
  int beat = 0;
  bit prev_wait = 0;
  logic [15:0] prev_addr = '0;

  always @(negedge clk) begin
    if (rst && prev_wait)
      check("mem_hold", {15'd0, bus.mem_req, bus.mem_addr},
            {15'd0, 1'b1, prev_addr});
    if (!rst || !bus.mem_req) begin
      bus.mem_ack = 1'b0;
      cnt = 0;
      beat = 0;
      prev_wait = 0;
    end else if (cnt >= mem_wait) begin
      check("beat_addr", {16'd0, bus.mem_addr},
            {16'd0, cur_addr[15:4], 2'(beat), 2'b00});
      bus.mem_ack = 1'b1;
      bus.mem_rdata = memword(bus.mem_addr);
      cnt = 0;
      beat++;
      ack_total++;
      prev_wait = 0;
    end else begin
      bus.mem_ack = 1'b0;
      cnt++;
      prev_wait = 1;
      prev_addr = bus.mem_addr;
    end
  end

  // Reference: per set, up to two resident tags kept in MRU-first order
  logic [5:0] mtag [64][2];
  int mcnt [64];
  int mhits = 0;
  int mmiss = 0;

  function automatic bit model_access(input logic [15:0] a);
    int s;
    logic [5:0] t;
    s = int'(a[9:4]);
    t = a[15:10];
    if (mcnt[s] > 0 && mtag[s][0] == t) begin
      mhits++;
      return 1'b1;
    end
    if (mcnt[s] > 1 && mtag[s][1] == t) begin
      mtag[s][1] = mtag[s][0];
      mtag[s][0] = t;
      mhits++;
      return 1'b1;
    end
    mtag[s][1] = mtag[s][0];
    mtag[s][0] = t;
    if (mcnt[s] < 2) mcnt[s]++;
    mmiss++;
    return 1'b0;
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 64; s++) mcnt[s] = 0;
  endfunction

  task automatic check_perf(input string nm);
`ifdef ICACHE_PERF_EN
    check({nm, "_hit_cnt"}, bus.hit_cnt, 32'(mhits));
    check({nm, "_miss_cnt"}, bus.miss_cnt, 32'(mmiss));
`else
    check({nm, "_hit_cnt"}, bus.hit_cnt, 32'd0);
    check({nm, "_miss_cnt"}, bus.miss_cnt, 32'd0);
`endif
  endtask

  task automatic do_read(input logic [15:0] a, output logic hit,
                         output logic [31:0] d, output int lat,
                         output logic rdy_after);
    int guard;
    bit saw_req;
    guard = 0;
    @(negedge clk);
    while (!bus.cpu_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    cur_addr = a;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = a;
    @(posedge clk);
    #1;
    bus.cpu_req = 1'b0;
    bus.cpu_addr = 16'($urandom);
    lat = 0;
    saw_req = 0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_req) saw_req = 1;
    end while (!bus.cpu_valid && lat < 400);
    if (!bus.cpu_valid) lat = -1;
    d = bus.cpu_rdata;
    hit = !saw_req;
    @(negedge clk);
    rdy_after = bus.cpu_ready && !bus.cpu_valid;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        hit;
    logic [31:0] data;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit at %0t", $time);
    $fatal(1);
  end

  initial begin
    logic hit, rdy;
    logic [31:0] d;
    logic [15:0] a;
    int lat, w;
    bit eh;

    vecs[0] = '{16'h0040, 1'b0, 32'h0000_00A0};
    vecs[1] = '{16'h0048, 1'b1, 32'h0000_00A2};
    vecs[2] = '{16'h0440, 1'b0, memword(16'h0440)};
    vecs[3] = '{16'h0040, 1'b1, 32'h0000_00A0};
    vecs[4] = '{16'h0840, 1'b0, memword(16'h0840)};
    vecs[5] = '{16'h0044, 1'b1, 32'h0000_00A1};
    vecs[6] = '{16'h0440, 1'b0, memword(16'h0440)};
    vecs[7] = '{16'h0444, 1'b1, memword(16'h0444)};

    bus.cpu_req = 1'b0;
    bus.cpu_addr = '0;
    bus.flush = 1'b0;
    model_flush();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", bus.cpu_ready, 1);
    check("rst_valid", bus.cpu_valid, 0);
    check("rst_rdata", bus.cpu_rdata, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check_perf("rst");
    #1 rst = 1'b1;

    for (int i = 0; i < 8; i++) begin
      mem_wait = 0;
      do_read(vecs[i].addr, hit, d, lat, rdy);
      void'(model_access(vecs[i].addr));
      check("vec_hit", hit, vecs[i].hit);
      check("vec_data", d, vecs[i].data);
      check("vec_lat", lat, vecs[i].hit ? 1 : 5);
      check("vec_ready", rdy, 1);
      if (i == 1) check_perf("scen1");
    end

    mem_wait = 10;
    do_read(16'h0200, hit, d, lat, rdy);
    void'(model_access(16'h0200));
    check("slow_hit", hit, 0);
    check("slow_data", d, memword(16'h0200));
    check("slow_lat", lat, 1 + 4 * 11);

    mem_wait = 2;
    fork
      do_read(16'h0100, hit, d, lat, rdy);
      begin
        int start, g;
        start = ack_total;
        g = 0;
        while (ack_total == start && g < 200) begin
          @(negedge clk);
          g++;
        end
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
      end
    join
    void'(model_access(16'h0100));
    model_flush();
    check("flush_hit", hit, 0);
    check("flush_data", d, memword(16'h0100));
    check("flush_lat", lat, 13);
    check("flush_ready", rdy, 0);
    do_read(16'h0100, hit, d, lat, rdy);
    void'(model_access(16'h0100));
    check("flush_reread_hit", hit, 0);
    check("flush_reread_lat", lat, 13);
    do_read(16'h0048, hit, d, lat, rdy);
    void'(model_access(16'h0048));
    check("flush_old_hit", hit, 0);
    check("flush_old_data", d, 32'hA2);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        model_flush();
      end
      a = {6'($urandom_range(0, 3)), 6'($urandom_range(0, 3)),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      w = int'($urandom_range(0, 2));
      mem_wait = w;
      do_read(a, hit, d, lat, rdy);
      eh = model_access(a);
      check("rnd_hit", hit, eh);
      check("rnd_data", d, memword({a[15:2], 2'b00}));
      check("rnd_lat", lat, eh ? 1 : 1 + 4 * (w + 1));
      check("rnd_ready", rdy, 1);
    end

    mem_wait = 0;
    do_read(16'h0040, hit, d, lat, rdy);
    eh = model_access(16'h0040);
    check("pre_rst_hit", hit, eh);
    check("pre_rst_data", d, 32'hA0);

    mem_wait = 3;
    @(negedge clk);
    cur_addr = 16'h0300;
    bus.cpu_req = 1'b1;
    bus.cpu_addr = 16'h0300;
    @(posedge clk);
    #1 bus.cpu_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mid_req_before", bus.mem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_mem_req", bus.mem_req, 0);
    check("rst_mid_valid", bus.cpu_valid, 0);
    check("rst_mid_mem_addr", bus.mem_addr, 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    model_flush();
    mhits = 0;
    mmiss = 0;

    mem_wait = 0;
    do_read(16'h0040, hit, d, lat, rdy);
    void'(model_access(16'h0040));
    check("rst_reread_hit", hit, 0);
    check("rst_reread_data", d, 32'hA0);
    check("rst_reread_lat", lat, 5);
    check_perf("final");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
